// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory arbiter.
//   owner_t     : which master owns the outstanding access
//   state_t     : arbiter sequencing state
//   MEM_LAT_MAX : largest supported memory read latency
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int MEM_LAT_MAX = 4;

  // Grant vector bit positions shared by the picker and the top level.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   en       : grant window open; no grant when low
//   req_if   : fetch master requesting
//   req_d    : data master requesting
//   last_gnt : master granted most recently (held by the parent)
//   gnt      : one-hot grant, bit GNT_IF = fetch, bit GNT_D = data
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       en,
  input  logic       req_if,
  input  logic       req_d,
  input  owner_t     last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_if && req_d) begin
        // Tie: the master that was not served last goes first.
        if (last_gnt == OWN_D) gnt[GNT_IF] = 1'b1;
        else                   gnt[GNT_D]  = 1'b1;
      end else begin
        gnt[GNT_IF] = req_if;
        gnt[GNT_D]  = req_d;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one fixed-latency single-port memory between the core's
// instruction-fetch port (if_*) and load/store port (d_*). One access is
// outstanding at a time; the response is routed back to its owner.
//
// Handshake: a master holds *_req_i and its fields until *_gnt_o is seen
// high in the same cycle; the access is issued on mem_* in that cycle and
// *_rvalid_o pulses for one cycle exactly MEM_LAT cycles later. There is no
// backpressure on responses.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req_i/if_addr_i       fetch request and address
//   if_gnt_o                 fetch accepted this cycle
//   if_rvalid_o/if_rdata_o   fetch response (rdata 0 outside the pulse)
//   d_req_i/d_we_i/d_addr_i/d_wdata_i/d_wstrb_i  load/store request
//   d_gnt_o                  load/store accepted this cycle
//   d_rvalid_o/d_rdata_o     read data or write ack (rdata 0 on ack)
//   mem_en_o..mem_wstrb_o    memory access, valid in the grant cycle
//   mem_rdata_i              memory read data, MEM_LAT cycles after mem_en_o
//   dbg_state_o              current sequencing state
//
// MEM_LAT must lie in 1..MEM_LAT_MAX; DATA_W must be a multiple of 8.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output state_t              dbg_state_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  owner_t           owner;
  owner_t           last_gnt;
  logic             own_we;

  logic             last_cycle;
  logic             resp;
  logic             win;
  logic [1:0]       gnt;

  // Final latency cycle: response out, and a new grant may overlap it.
  // Reset gates every output so the block is silent while rst is high.
  assign last_cycle = (state == S_WAIT) && (cnt == '0);
  assign resp       = !rst && last_cycle;
  assign win        = !rst && ((state == S_IDLE) || last_cycle);

  rr_arb2 u_pick (
    .en       (win),
    .req_if   (if_req_i),
    .req_d    (d_req_i),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign if_gnt_o    = gnt[GNT_IF];
  assign d_gnt_o     = gnt[GNT_D];
  assign dbg_state_o = state;

  always_comb begin
    mem_en_o    = gnt[GNT_IF] | gnt[GNT_D];
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (gnt[GNT_D]) begin
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_wstrb_o = d_we_i ? d_wstrb_i : '0;
    end else if (gnt[GNT_IF]) begin
      mem_addr_o  = if_addr_i;
    end
  end

  assign if_rvalid_o = resp && (owner == OWN_IF);
  assign d_rvalid_o  = resp && (owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = (d_rvalid_o && !own_we) ? mem_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      owner    <= OWN_IF;
      last_gnt <= OWN_D;
      own_we   <= 1'b0;
    end else if (gnt[GNT_IF] || gnt[GNT_D]) begin
      state    <= S_WAIT;
      cnt      <= CNT_W'(MEM_LAT - 1);
      owner    <= gnt[GNT_D] ? OWN_D : OWN_IF;
      last_gnt <= gnt[GNT_D] ? OWN_D : OWN_IF;
      own_we   <= gnt[GNT_D] & d_we_i;
    end else if (state == S_WAIT) begin
      if (cnt == '0) state <= S_IDLE;
      else           cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances with MEM_LAT = 1, 2, 3
// (index 0, 1, 2) share clock and reset; each has its own stimulus and a
// fixed-latency memory model returning mem_fn(addr).
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int N  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          if_req   [N];
  logic [AW-1:0] if_addr  [N];
  logic          if_gnt   [N];
  logic          if_rvalid[N];
  logic [DW-1:0] if_rdata [N];
  logic          d_req    [N];
  logic          d_we     [N];
  logic [AW-1:0] d_addr   [N];
  logic [DW-1:0] d_wdata  [N];
  logic [SW-1:0] d_wstrb  [N];
  logic          d_gnt    [N];
  logic          d_rvalid [N];
  logic [DW-1:0] d_rdata  [N];
  logic          mem_en   [N];
  logic          mem_we   [N];
  logic [AW-1:0] mem_addr [N];
  logic [DW-1:0] mem_wdata[N];
  logic [SW-1:0] mem_wstrb[N];
  logic [DW-1:0] mem_rdata[N];
  state_t        dbg_state[N];

  int n_checks = 0;
  int n_err    = 0;
  // Scoreboard entries: {owner_is_d, expected rdata}
  logic [DW:0] exp_q[$];

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [DW-1:0] sr[LAT];

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req_i    (if_req[g]),
      .if_addr_i   (if_addr[g]),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .d_req_i     (d_req[g]),
      .d_we_i      (d_we[g]),
      .d_addr_i    (d_addr[g]),
      .d_wdata_i   (d_wdata[g]),
      .d_wstrb_i   (d_wstrb[g]),
      .d_gnt_o     (d_gnt[g]),
      .d_rvalid_o  (d_rvalid[g]),
      .d_rdata_o   (d_rdata[g]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_wstrb_o (mem_wstrb[g]),
      .mem_rdata_i (mem_rdata[g]),
      .dbg_state_o (dbg_state[g])
    );

    // Memory model: data for an access issued in cycle N is on the bus in
    // cycle N+LAT; a junk pattern marks cycles with no access behind them.
    always @(posedge clk) begin
      sr[0] <= mem_en[g] ? mem_fn(mem_addr[g]) : 32'hBAD0BAD0;
      for (int k = 1; k < LAT; k++) sr[k] <= sr[k-1];
    end
    assign mem_rdata[g] = sr[LAT-1];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input int i, input string tag, input logic ig, input logic dg,
                           input logic iv, input logic dv, input logic me);
    check({tag, " if_gnt"},    64'(if_gnt[i]),    64'(ig));
    check({tag, " d_gnt"},     64'(d_gnt[i]),     64'(dg));
    check({tag, " if_rvalid"}, 64'(if_rvalid[i]), 64'(iv));
    check({tag, " d_rvalid"},  64'(d_rvalid[i]),  64'(dv));
    check({tag, " mem_en"},    64'(mem_en[i]),    64'(me));
  endtask

  // ---------------- drivers ----------------
  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0; d_wstrb[i] = '0;
    end
  endtask

  task automatic drive_if(input int i, input logic req, input logic [AW-1:0] a);
    if_req[i] = req; if_addr[i] = a;
  endtask

  task automatic drive_d(input int i, input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    d_req[i] = req; d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd; d_wstrb[i] = ws;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset: outputs silent even with requests present ----
    idle_all();
    for (int i = 0; i < N; i++) begin
      drive_if(i, 1'b1, 32'h4);
      drive_d(i, 1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, '1);
    end
    #2;
    for (int i = 0; i < N; i++) begin
      check_ctl(i, $sformatf("rst%0d", i), 0, 0, 0, 0, 0);
      check($sformatf("rst%0d mem_we", i), 64'(mem_we[i]), 64'd0);
      check($sformatf("rst%0d mem_wstrb", i), 64'(mem_wstrb[i]), 64'd0);
    end
    do_reset();
    sample();
    for (int i = 0; i < N; i++) begin
      check($sformatf("post_rst%0d state", i), 64'(dbg_state[i]), 64'(S_IDLE));
      check_ctl(i, $sformatf("post_rst%0d", i), 0, 0, 0, 0, 0);
    end
    next_cycle();

    // ---- T1: single fetch, MEM_LAT=1 ----
    drive_if(0, 1'b1, 32'h10);
    sample();
    check_ctl(0, "t1 c0", 1, 0, 0, 0, 1);
    check("t1 c0 mem_addr", 64'(mem_addr[0]), 64'h10);
    check("t1 c0 mem_we", 64'(mem_we[0]), 64'd0);
    check("t1 c0 mem_wstrb", 64'(mem_wstrb[0]), 64'd0);
    next_cycle();
    drive_if(0, 1'b0, 32'h0);
    sample();
    check_ctl(0, "t1 c1", 0, 0, 1, 0, 0);
    check("t1 c1 if_rdata", 64'(if_rdata[0]), 64'hDEADBEEF);
    next_cycle();
    sample();
    check_ctl(0, "t1 c2", 0, 0, 0, 0, 0);
    check("t1 c2 if_rdata", 64'(if_rdata[0]), 64'd0);
    next_cycle();

    // ---- T2: both masters continuously, MEM_LAT=1 ----
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 7; c++) begin
      drive_if(0, c < 6, 32'h100);
      drive_d(0, c < 6, 1'b0, 32'h200, 32'h0, 4'h0);
      sample();
      if (c < 6) begin
        check($sformatf("t2 c%0d if_gnt", c), 64'(if_gnt[0]), 64'(c % 2 == 0));
        check($sformatf("t2 c%0d d_gnt", c),  64'(d_gnt[0]),  64'(c % 2 == 1));
        check($sformatf("t2 c%0d mem_addr", c), 64'(mem_addr[0]),
              (c % 2 == 0) ? 64'h100 : 64'h200);
      end
      check($sformatf("t2 c%0d resp", c), 64'(if_rvalid[0] | d_rvalid[0]), 64'(c >= 1));
      if (if_rvalid[0] || d_rvalid[0]) begin
        if (exp_q.size() == 0) check($sformatf("t2 c%0d unexpected resp", c), 64'd1, 64'd0);
        else check($sformatf("t2 c%0d resp data", c),
                   {31'd0, d_rvalid[0], d_rvalid[0] ? d_rdata[0] : if_rdata[0]},
                   64'(exp_q.pop_front()));
      end
      if (if_gnt[0]) exp_q.push_back({1'b0, mem_fn(32'h100)});
      if (d_gnt[0])  exp_q.push_back({1'b1, mem_fn(32'h200)});
      next_cycle();
    end
    check("t2 queue empty", 64'(exp_q.size()), 64'd0);

    // ---- T3: data write, MEM_LAT=3, fetch held meanwhile ----
    do_reset();
    drive_d(2, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011);
    sample();
    check_ctl(2, "t3 c0", 0, 1, 0, 0, 1);
    check("t3 c0 mem_we", 64'(mem_we[2]), 64'd1);
    check("t3 c0 mem_wstrb", 64'(mem_wstrb[2]), 64'h3);
    check("t3 c0 mem_addr", 64'(mem_addr[2]), 64'h20);
    check("t3 c0 mem_wdata", 64'(mem_wdata[2]), 64'h12345678);
    next_cycle();
    drive_d(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_if(2, 1'b1, 32'h30);
    for (int c = 1; c < 3; c++) begin
      sample();
      check_ctl(2, $sformatf("t3 c%0d", c), 0, 0, 0, 0, 0);
      next_cycle();
    end
    sample();
    check_ctl(2, "t3 c3", 1, 0, 0, 1, 1);
    check("t3 c3 d_rdata", 64'(d_rdata[2]), 64'd0);
    check("t3 c3 mem_addr", 64'(mem_addr[2]), 64'h30);
    check("t3 c3 mem_we", 64'(mem_we[2]), 64'd0);
    next_cycle();
    drive_if(2, 1'b0, 32'h0);
    for (int c = 4; c < 6; c++) begin
      sample();
      check_ctl(2, $sformatf("t3 c%0d", c), 0, 0, 0, 0, 0);
      next_cycle();
    end
    sample();
    check_ctl(2, "t3 c6", 0, 0, 1, 0, 0);
    check("t3 c6 if_rdata", 64'(if_rdata[2]), 64'hC0DE0030);
    next_cycle();

    // ---- T4: MEM_LAT=2, fetch pending behind a data read ----
    do_reset();
    drive_d(1, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'hF);
    sample();
    check_ctl(1, "t4 c0", 0, 1, 0, 0, 1);
    check("t4 c0 mem_we", 64'(mem_we[1]), 64'd0);
    check("t4 c0 mem_wstrb", 64'(mem_wstrb[1]), 64'd0);
    next_cycle();
    drive_d(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_if(1, 1'b1, 32'h50);
    sample();
    check_ctl(1, "t4 c1", 0, 0, 0, 0, 0);
    next_cycle();
    sample();
    check_ctl(1, "t4 c2", 1, 0, 0, 1, 1);
    check("t4 c2 d_rdata", 64'(d_rdata[1]), 64'hC0DE0040);
    next_cycle();
    drive_if(1, 1'b0, 32'h0);
    sample();
    check_ctl(1, "t4 c3", 0, 0, 0, 0, 0);
    next_cycle();
    sample();
    check_ctl(1, "t4 c4", 0, 0, 1, 0, 0);
    check("t4 c4 if_rdata", 64'(if_rdata[1]), 64'hC0DE0050);
    next_cycle();

    // ---- T5: reset right after a grant, MEM_LAT=3 ----
    do_reset();
    drive_if(2, 1'b1, 32'h60);
    sample();
    check_ctl(2, "t5 c0", 1, 0, 0, 0, 1);
    next_cycle();
    drive_if(2, 1'b0, 32'h0);
    rst = 1'b1;
    sample();
    check_ctl(2, "t5 c1", 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    for (int c = 2; c < 6; c++) begin
      sample();
      if (c == 2) check("t5 c2 state", 64'(dbg_state[2]), 64'(S_IDLE));
      check_ctl(2, $sformatf("t5 c%0d", c), 0, 0, 0, 0, 0);
      next_cycle();
    end
    drive_if(2, 1'b1, 32'h64);
    drive_d(2, 1'b1, 1'b0, 32'h68, 32'h0, 4'h0);
    sample();
    check_ctl(2, "t5 tie", 1, 0, 0, 0, 1);
    next_cycle();
    idle_all();

    // ---- T6: data request dropped while fetches own the bus, MEM_LAT=3 ----
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive_if(2, 1'b1, 32'h70);
      drive_d(2, (c == 1) || (c == 2), 1'b1, 32'h80, 32'hA5A5A5A5, 4'hF);
      sample();
      check_ctl(2, $sformatf("t6 c%0d", c), c % 3 == 0, 0, (c % 3 == 0) && (c > 0), 0, c % 3 == 0);
      check($sformatf("t6 c%0d mem_we", c), 64'(mem_we[2]), 64'd0);
      if (if_rvalid[2]) check($sformatf("t6 c%0d if_rdata", c), 64'(if_rdata[2]), 64'hC0DE0070);
      next_cycle();
    end
    idle_all();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the SoC's single-port instruction/data memory between the core's instruction-fetch port and its load/store port. Accepts one transaction at a time, sequences it against a fixed-latency memory, and routes read data or write acknowledge back to the owning master. Sits in `open_risc_v_soc` between `open_risc_v` and the memory instance. Arbitration between the two masters is round-robin.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; must be a multiple of 8.
- `MEM_LAT`, 1, cycles from memory request to read data valid; legal range 1..4.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `if_req_i`  in  1  fetch request; held with address until granted.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch data valid, one-cycle pulse.
- `if_rdata_o`  out  DATA_W  fetch data.
- `d_req_i`  in  1  data request; held with all fields until granted.
- `d_we_i`  in  1  1 = write, 0 = read.
- `d_addr_i`  in  ADDR_W  data address.
- `d_wdata_i`  in  DATA_W  write data.
- `d_wstrb_i`  in  DATA_W/8  byte write enables.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_rvalid_o`  out  1  read data valid or write acknowledge, one-cycle pulse.
- `d_rdata_o`  out  DATA_W  read data; 0 on write acknowledge.
- `mem_en_o`  out  1  memory access strobe, one cycle per transaction.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_W  memory address.
- `mem_wdata_o`  out  DATA_W  memory write data.
- `mem_wstrb_o`  out  DATA_W/8  memory byte strobes; all 0 on reads.
- `mem_rdata_i`  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en_o`.

## Operation
- States: S_IDLE (no outstanding access) and S_WAIT (one outstanding access, latency counter running).
- Grant window: state S_IDLE, or state S_WAIT with the counter on its final cycle. This allows back-to-back transactions.
- In a grant window with at least one request:
  - The chosen master gets `*_gnt_o`=1 combinationally.
  - `mem_en_o`=1 and the mem_* fields are driven from that master's inputs in the same cycle.
  - The state goes to S_WAIT, the counter loads MEM_LAT-1, and the owner is recorded.
- Only one request pending: that master wins.
- Both requests pending: the master not granted last wins.
- `last_gnt` resets to DATA, so the first tie goes to fetch.
- In S_WAIT the counter decrements each cycle. When it reaches 0, the response is emitted for the recorded owner:
  - `*_rvalid_o`=1.
  - `*_rdata_o` = `mem_rdata_i` for a read, 0 for a write.
- With no new grant in the response cycle, the state returns to S_IDLE.
- Outside the response cycle, `rdata` outputs are 0; rvalid for the non-owner is always 0.
- Outside a grant cycle, `mem_en_o`, `mem_we_o` and `mem_wstrb_o` are 0; addr and wdata are don't-care.
- Fetch transactions always drive `mem_we_o`=0 and `mem_wstrb_o`=0.
- A request that drops before grant is legal and is simply not served.

## Timing
- Reset values:
  - All outputs are 0.
  - State is S_IDLE, counter is 0, owner is IF, `last_gnt` is DATA.
- Reset mid-transaction drops the outstanding access. No rvalid is emitted for it after reset.
- Latency: grant in cycle N gives rvalid in cycle N+MEM_LAT.
- Throughput: one transaction per MEM_LAT cycles under continuous requests.
  - MEM_LAT=1: a grant every cycle.
  - Under a tie in every cycle, grants alternate IF, D, IF, D...
- In the response cycle, rvalid for transaction k and gnt for transaction k+1 may both be 1, possibly to the same master.
- Counter width is clog2(MEM_LAT+1).

## Structure
- Package `mem_arb_pkg` holds:
  - `owner_t` enum: OWN_IF, OWN_D.
  - `state_t` enum: S_IDLE, S_WAIT.
  - `MEM_LAT_MAX` = 4.
- Sub-module `rr_arb2` is a 2-way round-robin picker.
  - Inputs: two request lines, `last_gnt`, and an enable.
  - Output: a one-hot grant.
  - Purely combinational. `last_gnt` is held in the parent.

## Test plan
- Reset then a single fetch, addr 0x10, memory returns 0xDEADBEEF, MEM_LAT=1 -> `if_gnt_o` in cycle N, `if_rvalid_o` with 0xDEADBEEF in N+1, `mem_en_o` a single pulse in N.
- Both masters requesting continuously, MEM_LAT=1 -> grants IF, D, IF, D on consecutive cycles; each rvalid is 1 cycle after its grant and goes to the correct master.
- Data write: addr 0x20, wdata 0x12345678, wstrb 4'b0011, MEM_LAT=3 -> `mem_we_o`=1 with wstrb 0011 in the grant cycle; `d_rvalid_o`=1 with rdata 0 three cycles later; no grant in between, even with `if_req_i` held.
- MEM_LAT=2, fetch pending while data is outstanding -> fetch grant coincides with `d_rvalid_o`; the next `mem_en_o` is 2 cycles after the previous one.
- `rst` asserted in the cycle after a grant with MEM_LAT=3 -> no rvalid ever appears for that access; the next tie goes to IF.
- Data request raised then dropped while fetches own the bus -> no `d_gnt_o`, no `mem_we_o`; fetches unaffected.
